// File: rtl/conv_stream_3x3_pkg.sv
// Shared defaults and mode encoding for the streaming 3x3 convolution engine.
package conv_stream_3x3_pkg;

  localparam int unsigned BIT_LEN_DEF   = 8;
  localparam int unsigned M_LEN_DEF     = 3;
  localparam int unsigned CONV_LEN_DEF  = 20;
  localparam int unsigned CONV_LPOS_DEF = 13;

  typedef enum logic {
    KERNEL = 1'b0,
    IMAGE  = 1'b1
  } mode_t;

endpackage

// File: rtl/conv_column_shreg.sv
// Column shift register: slot 0 holds the newest column, slot M_LEN-1 the oldest.
module conv_column_shreg #(
  parameter int unsigned BIT_LEN = 8,
  parameter int unsigned M_LEN   = 3
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      en,
  input  logic [M_LEN-1:0][BIT_LEN-1:0]             col,
  output logic [M_LEN-1:0][M_LEN-1:0][BIT_LEN-1:0]  slots  // [slot][row]
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots <= '0;
    end else if (en) begin
      for (int unsigned s = M_LEN - 1; s > 0; s--) begin
        slots[s] <= slots[s-1];
      end
      slots[0] <= col;
    end
  end

endmodule

// File: rtl/conv_stream_3x3.sv
// Streaming 3x3 convolution: kernel/window column shift registers, registered
// product array, and a registered, arithmetically shifted sum in o_data.
module conv_stream_3x3
  import conv_stream_3x3_pkg::*;
#(
  parameter int unsigned BIT_LEN   = BIT_LEN_DEF,
  parameter int unsigned M_LEN     = M_LEN_DEF,
  parameter int unsigned CONV_LEN  = CONV_LEN_DEF,
  parameter int unsigned CONV_LPOS = CONV_LPOS_DEF
) (
  input  logic                        CLK100MHZ,
  input  logic                        i_reset,
  input  logic                        i_valid,
  input  logic                        i_selecK_I,
  input  logic        [BIT_LEN-1:0]   i_dato0,
  input  logic        [BIT_LEN-1:0]   i_dato1,
  input  logic        [BIT_LEN-1:0]   i_dato2,
  output logic signed [CONV_LPOS-1:0] o_data
);

  localparam int unsigned SHIFT = CONV_LEN - CONV_LPOS;

  mode_t                                     mode;
  logic                                      k_en;
  logic                                      img_en;
  logic [M_LEN-1:0][BIT_LEN-1:0]             col;
  logic [M_LEN-1:0][M_LEN-1:0][BIT_LEN-1:0]  k_slots;
  logic [M_LEN-1:0][M_LEN-1:0][BIT_LEN-1:0]  w_slots;
  logic [M_LEN-1:0][M_LEN-1:0][2*BIT_LEN-1:0] prod;   // [slot][row]
  logic signed [CONV_LEN-1:0]                acc;

  assign mode   = mode_t'(i_selecK_I);
  assign k_en   = i_valid && (mode == KERNEL);
  assign img_en = i_valid && (mode == IMAGE);
  assign col    = {i_dato2, i_dato1, i_dato0};

  conv_column_shreg #(
    .BIT_LEN (BIT_LEN),
    .M_LEN   (M_LEN)
  ) u_kernel (
    .clk   (CLK100MHZ),
    .rst_n (i_reset),
    .en    (k_en),
    .col   (col),
    .slots (k_slots)
  );

  conv_column_shreg #(
    .BIT_LEN (BIT_LEN),
    .M_LEN   (M_LEN)
  ) u_window (
    .clk   (CLK100MHZ),
    .rst_n (i_reset),
    .en    (img_en),
    .col   (col),
    .slots (w_slots)
  );

  // Products sample the window as it stood before this edge's column shift.
  always_ff @(posedge CLK100MHZ or negedge i_reset) begin
    if (!i_reset) begin
      prod <= '0;
    end else if (img_en) begin
      for (int unsigned s = 0; s < M_LEN; s++) begin
        for (int unsigned r = 0; r < M_LEN; r++) begin
          prod[s][r] <= $signed(k_slots[s][r]) * $signed(w_slots[s][r]);
        end
      end
    end
  end

  always_comb begin
    acc = '0;
    for (int unsigned s = 0; s < M_LEN; s++) begin
      for (int unsigned r = 0; r < M_LEN; r++) begin
        acc = acc + CONV_LEN'($signed(prod[s][r]));
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge i_reset) begin
    if (!i_reset) begin
      o_data <= '0;
    end else if (img_en) begin
      o_data <= CONV_LPOS'(acc >>> SHIFT);
    end
  end

endmodule

// File: tb/tb_conv_stream_3x3.sv
// Scoreboard bench for conv_stream_3x3: expected results queued at each image edge.
module tb_conv_stream_3x3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic        sel;
  logic [7:0]  d0, d1, d2;
  logic [12:0] o_data;

  int checks = 0;
  int errors = 0;
  int mk [3][3];   // [slot][row]
  int mw [3][3];
  int q [$];

  always #5 clk = ~clk;

  conv_stream_3x3 #(
    .BIT_LEN   (8),
    .M_LEN     (3),
    .CONV_LEN  (20),
    .CONV_LPOS (13)
  ) dut (
    .CLK100MHZ  (clk),
    .i_reset    (rst_n),
    .i_valid    (valid),
    .i_selecK_I (sel),
    .i_dato0    (d0),
    .i_dato1    (d1),
    .i_dato2    (d2),
    .o_data     (o_data)
  );

  function automatic int conv_model();
    int sum = 0;
    for (int s = 0; s < 3; s++)
      for (int r = 0; r < 3; r++)
        sum += mk[s][r] * mw[s][r];
    return sum >>> 7;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++)
      for (int r = 0; r < 3; r++) begin
        mk[s][r] = 0;
        mw[s][r] = 0;
      end
    q.delete();
    q.push_back(0);
  endtask

  task automatic drive_kernel(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    @(negedge clk);
    sel = 1'b0; d0 = a; d1 = b; d2 = c; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    for (int s = 2; s > 0; s--)
      for (int r = 0; r < 3; r++) mk[s][r] = mk[s-1][r];
    mk[0][0] = int'($signed(a));
    mk[0][1] = int'($signed(b));
    mk[0][2] = int'($signed(c));
  endtask

  task automatic drive_image(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             output int exp);
    @(negedge clk);
    sel = 1'b1; d0 = a; d1 = b; d2 = c; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    q.push_back(conv_model());
    for (int s = 2; s > 0; s--)
      for (int r = 0; r < 3; r++) mw[s][r] = mw[s-1][r];
    mw[0][0] = int'($signed(a));
    mw[0][1] = int'($signed(b));
    mw[0][2] = int'($signed(c));
    exp = q.pop_front();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; sel = 1'b0; d0 = '0; d1 = '0; d2 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (o_data !== 13'h0000) begin
      errors++;
      $display("FAIL reset_hold: got %h expected 0000", o_data);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sel = 1'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if (o_data !== 13'h0000) begin
        errors++;
        $display("FAIL idle_after_reset[%0d]: got %h expected 0000", i, o_data);
      end
    end
  endtask

  task automatic test_single_coeff();
    int exp;
    drive_kernel(8'h94, 8'h00, 8'h00);
    drive_kernel(8'h00, 8'h00, 8'h00);
    drive_kernel(8'h00, 8'h00, 8'h00);
    for (int i = 1; i <= 5; i++) begin
      drive_image(8'h40, 8'h00, 8'h00, exp);
      checks++;
      if (o_data !== 13'(exp)) begin
        errors++;
        $display("FAIL single_coeff[%0d]: got %h expected %h", i, o_data, 13'(exp));
      end
    end
    checks++;
    if (o_data !== 13'h1FCA) begin
      errors++;
      $display("FAIL single_coeff_final: got %h expected 1fca", o_data);
    end
  endtask

  task automatic test_all_7f();
    int exp;
    repeat (3) drive_kernel(8'h7F, 8'h7F, 8'h7F);
    for (int i = 1; i <= 5; i++) begin
      drive_image(8'h7F, 8'h7F, 8'h7F, exp);
      checks++;
      if (o_data !== 13'(exp)) begin
        errors++;
        $display("FAIL all_7f[%0d]: got %h expected %h", i, o_data, 13'(exp));
      end
    end
    checks++;
    if (o_data !== 13'h046E) begin
      errors++;
      $display("FAIL all_7f_final: got %h expected 046e", o_data);
    end
  endtask

  task automatic test_all_80();
    int exp;
    repeat (3) drive_kernel(8'h80, 8'h80, 8'h80);
    for (int i = 1; i <= 5; i++) begin
      drive_image(8'h80, 8'h80, 8'h80, exp);
      checks++;
      if (o_data !== 13'(exp)) begin
        errors++;
        $display("FAIL all_80[%0d]: got %h expected %h", i, o_data, 13'(exp));
      end
    end
    checks++;
    if (o_data !== 13'h0480) begin
      errors++;
      $display("FAIL all_80_final: got %h expected 0480", o_data);
    end
  endtask

  task automatic test_valid_gap();
    int exp;
    logic [12:0] held;
    repeat (3) drive_kernel(8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < 4; i++) begin
      drive_image(8'($urandom), 8'($urandom), 8'($urandom), exp);
      checks++;
      if (o_data !== 13'(exp)) begin
        errors++;
        $display("FAIL gap_pre[%0d]: got %h expected %h", i, o_data, 13'(exp));
      end
    end
    held = 13'(exp);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      valid = 1'b0; sel = 1'($urandom);
      d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if (o_data !== held) begin
        errors++;
        $display("FAIL gap_hold[%0d]: got %h expected %h", i, o_data, held);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive_image(8'($urandom), 8'($urandom), 8'($urandom), exp);
      checks++;
      if (o_data !== 13'(exp)) begin
        errors++;
        $display("FAIL gap_resume[%0d]: got %h expected %h", i, o_data, 13'(exp));
      end
    end
  endtask

  task automatic test_back_to_back();
    int exp;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(3) == 0) begin
        drive_kernel(8'($urandom), 8'($urandom), 8'($urandom));
      end else begin
        drive_image(8'($urandom), 8'($urandom), 8'($urandom), exp);
        checks++;
        if (o_data !== 13'(exp)) begin
          errors++;
          $display("FAIL back_to_back[%0d]: got %h expected %h", i, o_data, 13'(exp));
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int exp;
    repeat (3) drive_kernel(8'h7F, 8'h7F, 8'h7F);
    repeat (5) drive_image(8'h7F, 8'h7F, 8'h7F, exp);
    checks++;
    if (o_data !== 13'h046E) begin
      errors++;
      $display("FAIL pre_reset_value: got %h expected 046e", o_data);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o_data !== 13'h0000) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0000", o_data);
    end
    #1 rst_n = 1'b1;
    model_reset();
    repeat (3) drive_kernel(8'h7F, 8'h7F, 8'h7F);
    for (int i = 1; i <= 5; i++) begin
      drive_image(8'h7F, 8'h7F, 8'h7F, exp);
      checks++;
      if (o_data !== 13'(exp)) begin
        errors++;
        $display("FAIL rebuild[%0d]: got %h expected %h", i, o_data, 13'(exp));
      end
    end
    checks++;
    if (o_data !== 13'h046E) begin
      errors++;
      $display("FAIL rebuild_final: got %h expected 046e", o_data);
    end
  endtask

  initial begin
    test_reset();
    test_single_coeff();
    test_all_7f();
    test_all_80();
    test_valid_gap();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
